// File: rtl/video_compositor_pkg.sv
// video_compositor_pkg: shared coordinate/counter types, default 640x480
// raster timing constants and the power-of-two scale helper.
package video_compositor_pkg;

  typedef logic [8:0] coord_t;
  typedef logic [9:0] raster_count_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Pixel and line repeat factors are powers of two, so scaling is a shift.
  function automatic int scale_shift(input int scale);
    return $clog2(scale);
  endfunction

endpackage

// File: rtl/video_compositor_raster_timing.sv
// raster_timing: free-running raster counters, raw active-low syncs, the
// drawing flag, logical current/next coordinates and the registered vblank flag.
module raster_timing
  import video_compositor_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int X_OFFSET  = 32,
  parameter int X_SCALE   = 1,
  parameter int Y_SCALE   = 2,
  parameter int ACTIVE_W  = 256,
  parameter int ACTIVE_H  = 240
) (
  input  logic          gpu_clk,
  input  logic          rst,
  output raster_count_t hcounter,
  output raster_count_t vcounter,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          drawing,
  output coord_t        current_x,
  output coord_t        current_y,
  output coord_t        next_x,
  output coord_t        next_y,
  output logic          in_vblank,
  output logic          in_vblank_next
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int X_SHIFT = scale_shift(X_SCALE);
  localparam int Y_SHIFT = scale_shift(Y_SCALE);

  localparam raster_count_t H_LAST   = raster_count_t'(H_TOTAL - 1);
  localparam raster_count_t V_LAST   = raster_count_t'(V_TOTAL - 1);
  localparam raster_count_t HS_START = raster_count_t'(H_VISIBLE + H_FRONT);
  localparam raster_count_t HS_END   = raster_count_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam raster_count_t VS_START = raster_count_t'(V_VISIBLE + V_FRONT);
  localparam raster_count_t VS_END   = raster_count_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam raster_count_t H_VIS    = raster_count_t'(H_VISIBLE);
  localparam raster_count_t V_VIS    = raster_count_t'(V_VISIBLE);
  localparam raster_count_t X_OFF    = raster_count_t'(X_OFFSET);
  localparam raster_count_t ACT_W    = raster_count_t'(ACTIVE_W);
  localparam raster_count_t ACT_H    = raster_count_t'(ACTIVE_H);
  localparam raster_count_t VB_START = raster_count_t'(ACTIVE_H * Y_SCALE);
  localparam coord_t        Y_WRAP   = coord_t'((V_TOTAL - 1) >> Y_SHIFT);

  raster_count_t x_rel;

  // Advance the pixel counter every clock; the line counter steps on each line wrap.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      hcounter <= '0;
      vcounter <= '0;
    end else if (hcounter == H_LAST) begin
      hcounter <= '0;
      vcounter <= (vcounter == V_LAST) ? '0 : vcounter + 10'd1;
    end else begin
      hcounter <= hcounter + 10'd1;
    end
  end

  // Derive syncs, logical coordinates and the drawing window from the counters.
  always_comb begin
    x_rel          = hcounter - X_OFF;
    current_x      = coord_t'(x_rel >> X_SHIFT);
    current_y      = coord_t'(vcounter >> Y_SHIFT);
    next_x         = (current_x == 9'd511) ? 9'd0 : current_x + 9'd1;
    next_y         = (current_y == Y_WRAP) ? 9'd0 : current_y + 9'd1;
    hsync_raw      = !((hcounter >= HS_START) && (hcounter < HS_END));
    vsync_raw      = !((vcounter >= VS_START) && (vcounter < VS_END));
    drawing        = (hcounter < H_VIS) && (vcounter < V_VIS) && (hcounter >= X_OFF) &&
                     ({1'b0, current_x} < ACT_W) && ({1'b0, current_y} < ACT_H);
    in_vblank_next = (vcounter >= VB_START);
  end

  // Vblank starts once the last drawn logical line has been scanned out.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) in_vblank <= 1'b0;
    else     in_vblank <= in_vblank_next;
  end

endmodule

// File: rtl/video_compositor.sv
// video_compositor: raster timing plus priority compositing of NUM_LAYERS
// layer colours into registered RGB with syncs delayed to match.
// Optional per-line interrupt enabled by defining VIDEO_COMPOSITOR_LINE_IRQ_EN.
module video_compositor
  import video_compositor_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int X_OFFSET   = 32,
  parameter int X_SCALE    = 1,
  parameter int Y_SCALE    = 2,
  parameter int ACTIVE_W   = 256,
  parameter int ACTIVE_H   = 240,
  parameter int NUM_LAYERS = 3,
  parameter int CHAN_BITS  = 2
) (
  input  logic                              gpu_clk,
  input  logic                              rst,
  input  logic [NUM_LAYERS*3*CHAN_BITS-1:0] layer_rgb_i,
  input  logic [NUM_LAYERS-1:0]             layer_valid_i,
  input  logic                              clr_vblank_irq_i,
  output logic [CHAN_BITS-1:0]              r_o,
  output logic [CHAN_BITS-1:0]              g_o,
  output logic [CHAN_BITS-1:0]              b_o,
  output logic                              hsync_o,
  output logic                              vsync_o,
  output logic [9:0]                        hcounter_o,
  output logic [9:0]                        vcounter_o,
  output logic [8:0]                        current_x_o,
  output logic [8:0]                        current_y_o,
  output logic [8:0]                        next_x_o,
  output logic [8:0]                        next_y_o,
  output logic                              in_vblank_o,
  output logic                              vblank_irq_o,
  output logic                              controller_start_fetch_o
`ifdef VIDEO_COMPOSITOR_LINE_IRQ_EN
  ,
  input  logic [8:0]                        line_cmp_i,
  input  logic                              clr_line_irq_i,
  output logic                              line_irq_o
`endif
);

  localparam int PIX_W = 3 * CHAN_BITS;

  raster_count_t        hcounter, vcounter;
  coord_t               current_x, current_y, next_x, next_y;
  logic                 hsync_raw, vsync_raw, drawing;
  logic                 in_vblank, in_vblank_next, vblank_set;
  logic [PIX_W-1:0]     pix, rgb_q;

  raster_timing #(
    .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
    .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
    .X_OFFSET  (X_OFFSET),  .X_SCALE (X_SCALE), .Y_SCALE (Y_SCALE),
    .ACTIVE_W  (ACTIVE_W),  .ACTIVE_H (ACTIVE_H)
  ) u_raster_timing (
    .gpu_clk        (gpu_clk),
    .rst            (rst),
    .hcounter       (hcounter),
    .vcounter       (vcounter),
    .hsync_raw      (hsync_raw),
    .vsync_raw      (vsync_raw),
    .drawing        (drawing),
    .current_x      (current_x),
    .current_y      (current_y),
    .next_x         (next_x),
    .next_y         (next_y),
    .in_vblank      (in_vblank),
    .in_vblank_next (in_vblank_next)
  );

  // Pick the lowest-index opaque layer; the background layer is always opaque.
  always_comb begin
    pix = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_valid_i[k] || (k == NUM_LAYERS - 1)) pix = layer_rgb_i[k*PIX_W +: PIX_W];
    end
  end

  // Register colour and syncs together so they stay aligned at the pins.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= '0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      rgb_q   <= drawing ? pix : '0;
      hsync_o <= hsync_raw;
      vsync_o <= vsync_raw;
    end
  end

  assign vblank_set = (in_vblank_next != in_vblank);

  // Flag both vblank edges; a new edge beats a coincident clear so none is lost.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst)                   vblank_irq_o <= 1'b1;
    else if (vblank_set)       vblank_irq_o <= 1'b1;
    else if (clr_vblank_irq_i) vblank_irq_o <= 1'b0;
  end

`ifdef VIDEO_COMPOSITOR_LINE_IRQ_EN
  localparam raster_count_t Y_PHASE_MASK = raster_count_t'(Y_SCALE - 1);

  logic line_set;

  assign line_set = (hcounter == '0) && ((vcounter & Y_PHASE_MASK) == '0) &&
                    (current_y == line_cmp_i);

  // Fire once at the start of the first repeat of the matching logical line.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst)                 line_irq_o <= 1'b0;
    else if (line_set)       line_irq_o <= 1'b1;
    else if (clr_line_irq_i) line_irq_o <= 1'b0;
  end
`endif

  assign r_o                      = rgb_q[2*CHAN_BITS +: CHAN_BITS];
  assign g_o                      = rgb_q[CHAN_BITS +: CHAN_BITS];
  assign b_o                      = rgb_q[0 +: CHAN_BITS];
  assign hcounter_o               = hcounter;
  assign vcounter_o               = vcounter;
  assign current_x_o              = current_x;
  assign current_y_o              = current_y;
  assign next_x_o                 = next_x;
  assign next_y_o                 = next_y;
  assign in_vblank_o              = in_vblank;
  assign controller_start_fetch_o = (hcounter < 10'd32) && (vcounter == '0);

endmodule
